ifu_fetch_queue: RTL and testbench

Parametrised successor to the single-register instruction fetch unit. It holds the fetch PC, drives the instruction-memory address, and checks each fetched word for alignment and address range. Fetched {pc, instr, exc_code} entries go into a DEPTH-entry queue, which decouples the IM from a stalling decode stage. Interrupt and branch redirects flush the queue. A faulting fetch parks the fetcher until the next redirect.

---
 rtl/ifu_fetch_queue_pkg.sv | 15 +
 rtl/ifu_fetch_queue_fifo.sv | 55 +++++
 rtl/ifu_fetch_queue.sv | 93 +++++++++
 tb/tb_ifu_fetch_queue.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/ifu_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch unit and its entry queue.
package ifu_fetch_queue_pkg;

    localparam logic [4:0]  EXC_NONE       = 5'h0;
    localparam logic [4:0]  EXC_ADEL       = 5'h4;
    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_4180;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  exc;
    } fetch_entry_t;

endpackage

// File: rtl/ifu_fetch_queue_fifo.sv
// Circular FIFO with synchronous flush. The head is read directly from registered storage.
module ifu_fetch_queue_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 69
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int CW = $clog2(DEPTH);
    localparam logic [CW:0] FULL_CNT = (CW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    wr_ptr;
    logic [CW-1:0]    rd_ptr;

    assign rdata = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ifu_fetch_queue.sv
// Fetch PC, address range check and fault parking, feeding a DEPTH-entry queue
// that decouples instruction memory from a stalling decode stage.
module ifu_fetch_queue
    import ifu_fetch_queue_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = ifu_fetch_queue_pkg::DEF_RESET_PC,
    parameter logic [31:0] EXC_VECTOR = ifu_fetch_queue_pkg::DEF_EXC_VECTOR,
    parameter logic [31:0] IM_LO      = 32'h0000_3000,
    parameter logic [31:0] IM_HI      = 32'h0000_6ffc,
    parameter int          DEPTH      = 4,
    parameter logic [4:0]  EXC_ADEL   = ifu_fetch_queue_pkg::EXC_ADEL
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   int_req,
    input  logic                   redir_valid,
    input  logic [31:0]            redir_pc,
    output logic [31:0]            im_addr,
    input  logic [31:0]            im_rdata,
    input  logic                   deq_ready,
    output logic                   out_valid,
    output logic [31:0]            out_pc,
    output logic [31:0]            out_instr,
    output logic [4:0]             out_exc_code,
    output logic [$clog2(DEPTH):0] count
);

    logic [31:0]  pc;
    logic         parked;
    logic         fault;
    logic         flush;
    logic         push;
    logic         pop;
    logic         empty;
    logic         full;
    fetch_entry_t wr_entry;
    fetch_entry_t head;

    assign im_addr = pc;
    assign fault   = (pc[1:0] != 2'b00) || (pc < IM_LO) || (pc > IM_HI);
    assign flush   = int_req || redir_valid;

    // Redirects win over queue traffic: nothing moves in a flush cycle.
    assign out_valid = !empty;
    assign pop       = !flush && out_valid && deq_ready;
    assign push      = !flush && !parked && (!full || pop);

    always_comb begin
        wr_entry.pc    = pc;
        wr_entry.instr = fault ? 32'h0 : im_rdata;
        wr_entry.exc   = fault ? EXC_ADEL : EXC_NONE;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc     <= RESET_PC;
            parked <= 1'b0;
        end else if (int_req) begin
            pc     <= EXC_VECTOR;
            parked <= 1'b0;
        end else if (redir_valid) begin
            pc     <= redir_pc;
            parked <= 1'b0;
        end else if (push) begin
            if (fault) begin
                parked <= 1'b1;
            end else begin
                pc <= pc + 32'd4;
            end
        end
    end

    ifu_fetch_queue_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (head),
        .count (count),
        .empty (empty),
        .full  (full)
    );

    assign out_pc       = head.pc;
    assign out_instr    = head.instr;
    assign out_exc_code = head.exc;

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Directed bench for ifu_fetch_queue: vector table plus hand sequences for full, fault and reset cases.
module tb_ifu_fetch_queue;

    logic        clk;
    logic        reset;
    logic        int_req;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic [31:0] im_addr;
    logic [31:0] im_rdata;
    logic        deq_ready;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [4:0]  out_exc_code;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] PAT = 32'hA5A5_0000;

    ifu_fetch_queue dut (
        .clk          (clk),
        .reset        (reset),
        .int_req      (int_req),
        .redir_valid  (redir_valid),
        .redir_pc     (redir_pc),
        .im_addr      (im_addr),
        .im_rdata     (im_rdata),
        .deq_ready    (deq_ready),
        .out_valid    (out_valid),
        .out_pc       (out_pc),
        .out_instr    (out_instr),
        .out_exc_code (out_exc_code),
        .count        (count)
    );

    assign im_rdata = im_addr ^ PAT;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        deq;
        logic        redir;
        logic [31:0] rpc;
        logic        intr;
        logic        ev;
        logic [31:0] epc;
        logic [4:0]  eexc;
        logic [31:0] eim;
        logic [2:0]  ecnt;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                            input logic [4:0] exc);
        chk({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
        chk({tag, ".pc"}, out_pc, pc);
        chk({tag, ".instr"}, out_instr, instr);
        chk({tag, ".exc"}, {27'b0, out_exc_code}, {27'b0, exc});
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    initial begin
        reset       = 1'b0;
        int_req     = 1'b0;
        redir_valid = 1'b0;
        redir_pc    = 32'h0;
        deq_ready   = 1'b0;

        //            deq redir rpc            int ev epc             exc   im             cnt
        tbl[0]  = '{1'b1, 1'b0, 32'h0,          1'b0, 1'b1, 32'h0000_3000, 5'h0, 32'h0000_3004, 3'd1};
        tbl[1]  = '{1'b1, 1'b0, 32'h0,          1'b0, 1'b1, 32'h0000_3004, 5'h0, 32'h0000_3008, 3'd1};
        tbl[2]  = '{1'b1, 1'b0, 32'h0,          1'b0, 1'b1, 32'h0000_3008, 5'h0, 32'h0000_300c, 3'd1};
        tbl[3]  = '{1'b0, 1'b0, 32'h0,          1'b0, 1'b1, 32'h0000_3008, 5'h0, 32'h0000_3010, 3'd2};
        tbl[4]  = '{1'b0, 1'b0, 32'h0,          1'b0, 1'b1, 32'h0000_3008, 5'h0, 32'h0000_3014, 3'd3};
        tbl[5]  = '{1'b0, 1'b0, 32'h0,          1'b0, 1'b1, 32'h0000_3008, 5'h0, 32'h0000_3018, 3'd4};
        tbl[6]  = '{1'b0, 1'b0, 32'h0,          1'b0, 1'b1, 32'h0000_3008, 5'h0, 32'h0000_3018, 3'd4};
        tbl[7]  = '{1'b1, 1'b0, 32'h0,          1'b0, 1'b1, 32'h0000_300c, 5'h0, 32'h0000_301c, 3'd4};
        tbl[8]  = '{1'b0, 1'b0, 32'h0,          1'b0, 1'b1, 32'h0000_300c, 5'h0, 32'h0000_301c, 3'd4};
        tbl[9]  = '{1'b1, 1'b0, 32'h0,          1'b0, 1'b1, 32'h0000_3010, 5'h0, 32'h0000_3020, 3'd4};
        tbl[10] = '{1'b0, 1'b1, 32'h0000_3100,  1'b0, 1'b0, 32'h0,          5'h0, 32'h0000_3100, 3'd0};
        tbl[11] = '{1'b0, 1'b0, 32'h0,          1'b0, 1'b1, 32'h0000_3100, 5'h0, 32'h0000_3104, 3'd1};
        tbl[12] = '{1'b0, 1'b1, 32'h0000_3200,  1'b1, 1'b0, 32'h0,          5'h0, 32'h0000_4180, 3'd0};
        tbl[13] = '{1'b0, 1'b0, 32'h0,          1'b0, 1'b1, 32'h0000_4180, 5'h0, 32'h0000_4184, 3'd1};

        do_reset();
        chk("rst.count", {29'b0, count}, 32'd0);
        chk("rst.valid", {31'b0, out_valid}, 32'd0);
        chk("rst.im_addr", im_addr, 32'h0000_3000);

        for (int i = 0; i < 14; i++) begin
            deq_ready   = tbl[i].deq;
            redir_valid = tbl[i].redir;
            redir_pc    = tbl[i].rpc;
            int_req     = tbl[i].intr;
            step();
            chk($sformatf("vec%0d.count", i), {29'b0, count}, {29'b0, tbl[i].ecnt});
            chk($sformatf("vec%0d.im_addr", i), im_addr, tbl[i].eim);
            chk($sformatf("vec%0d.valid", i), {31'b0, out_valid}, {31'b0, tbl[i].ev});
            if (tbl[i].ev) begin
                chk($sformatf("vec%0d.pc", i), out_pc, tbl[i].epc);
                chk($sformatf("vec%0d.instr", i), out_instr, tbl[i].epc ^ PAT);
                chk($sformatf("vec%0d.exc", i), {27'b0, out_exc_code}, {27'b0, tbl[i].eexc});
            end
        end
        redir_valid = 1'b0;
        int_req     = 1'b0;

        // Stall from reset until full, then drain while refilling.
        deq_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 10; i++) step();
        chk("stall.count", {29'b0, count}, 32'd4);
        chk("stall.im_addr", im_addr, 32'h0000_3010);
        deq_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            logic [31:0] epc;
            epc = 32'h0000_3000 + 32'(4 * i);
            chk_head($sformatf("drain%0d", i), epc, epc ^ PAT, 5'h0);
            chk($sformatf("drain%0d.count", i), {29'b0, count}, 32'd4);
            step();
        end

        // Misaligned redirect faults and parks; top-of-range then walks off the end.
        deq_ready   = 1'b0;
        redir_valid = 1'b1;
        redir_pc    = 32'h0000_3002;
        step();
        redir_valid = 1'b0;
        chk("mis.flush_count", {29'b0, count}, 32'd0);
        chk("mis.flush_valid", {31'b0, out_valid}, 32'd0);
        step();
        chk_head("mis", 32'h0000_3002, 32'h0, 5'h4);
        step();
        step();
        chk("mis.park_count", {29'b0, count}, 32'd1);
        chk("mis.park_im", im_addr, 32'h0000_3002);

        redir_valid = 1'b1;
        redir_pc    = 32'h0000_6ffc;
        step();
        redir_valid = 1'b0;
        chk("top.im", im_addr, 32'h0000_6ffc);
        step();
        chk_head("top", 32'h0000_6ffc, 32'h0000_6ffc ^ PAT, 5'h0);
        step();
        chk("over.count", {29'b0, count}, 32'd2);
        deq_ready = 1'b1;
        step();
        chk_head("over", 32'h0000_7000, 32'h0, 5'h4);
        chk("over.count1", {29'b0, count}, 32'd1);
        step();
        chk("over.park_count", {29'b0, count}, 32'd0);
        chk("over.park_valid", {31'b0, out_valid}, 32'd0);
        chk("over.park_im", im_addr, 32'h0000_7000);

        // One-cycle reset with entries queued.
        deq_ready   = 1'b0;
        redir_valid = 1'b1;
        redir_pc    = 32'h0000_3400;
        step();
        redir_valid = 1'b0;
        step();
        step();
        chk("mid.count_pre", {29'b0, count}, 32'd2);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("mid.count", {29'b0, count}, 32'd0);
        chk("mid.valid", {31'b0, out_valid}, 32'd0);
        chk("mid.im", im_addr, 32'h0000_3000);
        step();
        chk_head("mid.after", 32'h0000_3000, 32'h0000_3000 ^ PAT, 5'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
